power_domain_seq: RTL and testbench
===================================

POWER_DOMAIN_SEQ -- requirements
Module: power_domain_seq

Interface
REQ-001 The block SHALL have parameter STEP_CYCLES, default 4, giving the hold time in cycles of each non-ack sequence step (legal 1..255).
REQ-002 The block SHALL have parameter ACK_TIMEOUT, default 64, giving the maximum cycles spent waiting for the switch ack (legal 4..65535).
REQ-003 Port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst_i  input  1  asynchronous, active-high reset.
REQ-005 Port off_req_i  input  1  level request: 1 = domain off, 0 = domain on.
REQ-006 Port switch_ack_n_i  input  1  power-switch acknowledge, active-low, asynchronous to clk_i.
REQ-007 Port switch_n_o  output  1  power-switch control, 0 = switch closed (domain powered).
REQ-008 Port iso_n_o  output  1  isolation control, 0 = domain outputs isolated.
REQ-009 Port rst_n_o  output  1  domain reset, 0 = domain held in reset.
REQ-010 Port clk_en_o  output  1  domain clock enable, 1 = clock running.
REQ-011 Port on_o  output  1  1 only in state ON.
REQ-012 Port off_o  output  1  1 only in state OFF.
REQ-013 Port busy_o  output  1  1 in every state other than ON and OFF.
REQ-014 Port timeout_o  output  1  one-cycle pulse on ack timeout.

Function
REQ-015 switch_ack_n_i SHALL pass through a 2-flop synchronizer (ack_s) before use; ack_s lags the input by 2 edges.
REQ-016 The FSM SHALL have states ON, CLK_OFF, ISO_ON, RST_ON, SW_OFF, OFF, SW_ON, RST_OFF, ISO_OFF, CLK_ON.
REQ-017 All outputs except timeout_o SHALL be decoded from the state register only (Moore).
REQ-018 Outputs per state (switch_n,iso_n,rst_n,clk_en): ON 0,1,1,1; CLK_OFF 0,1,1,0; ISO_ON 0,0,1,0; RST_ON 0,0,0,0; SW_OFF 1,0,0,0; OFF 1,0,0,0; SW_ON 0,0,0,0; RST_OFF 0,0,1,0; ISO_OFF 0,1,1,0; CLK_ON 0,1,1,1.
REQ-019 ON with off_req_i=1 SHALL go to CLK_OFF on the next edge; ON with off_req_i=0 stays ON.
REQ-020 OFF with off_req_i=0 SHALL go to SW_ON on the next edge; OFF with off_req_i=1 stays OFF.
REQ-021 Timed states CLK_OFF, ISO_ON, RST_ON, RST_OFF, ISO_OFF, CLK_ON SHALL each last exactly STEP_CYCLES cycles, then advance: CLK_OFF->ISO_ON->RST_ON->SW_OFF; RST_OFF->ISO_OFF->CLK_ON->ON.
REQ-022 A single 8-bit step counter SHALL clear on every state entry.
REQ-023 SW_OFF SHALL advance to OFF on the edge where ack_s=1; SW_ON SHALL advance to RST_OFF on the edge where ack_s=0.
REQ-024 A 16-bit ack counter SHALL clear on entry to SW_OFF/SW_ON and increment each cycle in them; if ACK_TIMEOUT cycles elapse without the required ack_s level, the FSM SHALL advance as if acked and timeout_o SHALL be 1 for exactly the following cycle.
REQ-025 Ack arriving in the same cycle as timeout SHALL count as acked; timeout_o stays 0.
REQ-026 off_req_i SHALL be ignored in all busy states; a started sequence always completes, and the request is re-evaluated in ON/OFF.
REQ-027 ack_s changes outside SW_OFF/SW_ON SHALL have no effect.

Reset
REQ-028 While rst_i=1, state SHALL be ON: switch_n_o=0, iso_n_o=1, rst_n_o=1, clk_en_o=1, on_o=1, off_o=0, busy_o=0, timeout_o=0, counters and synchronizer zero.
REQ-029 Assertion of rst_i SHALL take effect asynchronously, including mid-sequence; release SHALL be followed by normal operation from ON on the first edge after rst_i=0.

Verification
REQ-030 STEP_CYCLES=4, off_req_i 0->1 at edge 0 in ON, ack_n follows switch_n_o after 16 cycles -> clk_en_o=0 at edge 1, iso_n_o=0 at 5, rst_n_o=0 at 9, switch_n_o=1 at 13, off_o=1 two to three edges after ack_n rises, timeout_o never 1.
REQ-031 From OFF, off_req_i=0 with 16-cycle ack -> switch_n_o=0 next edge, then rst_n_o=1, iso_n_o=1, clk_en_o=1 at 4-cycle spacing after ack_s=0, on_o=1 with clk_en_o.
REQ-032 ACK_TIMEOUT=8, switch_ack_n_i stuck 0 during power-off -> SW_OFF lasts 8 cycles, off_o=1 and timeout_o=1 for one cycle, then timeout_o=0.
REQ-033 off_req_i toggled 1->0 during ISO_ON -> sequence still reaches OFF, then immediately enters SW_ON and returns to ON.
REQ-034 rst_i pulsed during RST_ON -> outputs return to ON values within the reset assertion without a clock edge; on_o=1 after release.
REQ-035 ack_n glitch (1 cycle high) while in ON -> no state change, all outputs unchanged.

Source files
------------

// File: rtl/power_domain_seq_if.sv
// Control/status bundle between a power-domain sequencer and the domain's switch, isolation and reset cells.
interface power_domain_seq_if;
  logic off_req_i;
  logic switch_ack_n_i;
  logic switch_n_o;
  logic iso_n_o;
  logic rst_n_o;
  logic clk_en_o;
  logic on_o;
  logic off_o;
  logic busy_o;
  logic timeout_o;

  modport slave (
    input  off_req_i, switch_ack_n_i,
    output switch_n_o, iso_n_o, rst_n_o, clk_en_o, on_o, off_o, busy_o, timeout_o
  );

  modport master (
    output off_req_i, switch_ack_n_i,
    input  switch_n_o, iso_n_o, rst_n_o, clk_en_o, on_o, off_o, busy_o, timeout_o
  );
endinterface

// File: rtl/power_domain_seq.sv
// Power-domain sequencer: ordered clock-gate / isolate / reset / switch steps for power-down and the
// reverse for power-up, waiting on a synchronized switch acknowledge with a bounded timeout.
module power_domain_seq #(
  parameter int unsigned STEP_CYCLES = 4,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input logic clk_i,
  input logic rst_i,
  power_domain_seq_if.slave pd
);

  typedef enum logic [3:0] {
    ST_ON      = 4'd0,
    ST_CLK_OFF = 4'd1,
    ST_ISO_ON  = 4'd2,
    ST_RST_ON  = 4'd3,
    ST_SW_OFF  = 4'd4,
    ST_OFF     = 4'd5,
    ST_SW_ON   = 4'd6,
    ST_RST_OFF = 4'd7,
    ST_ISO_OFF = 4'd8,
    ST_CLK_ON  = 4'd9
  } state_t;

  localparam logic [7:0]  STEP_LAST = 8'(STEP_CYCLES - 1);
  localparam logic [15:0] ACK_LAST  = 16'(ACK_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  step_q, step_d;
  logic [15:0] ack_cnt_q, ack_cnt_d;
  logic        sync1_q, ack_s_q;
  logic        timeout_d, timeout_q;
  logic [6:0]  outs_q;

  // {switch_n, iso_n, rst_n, clk_en, on, off, busy} for a given state
  function automatic logic [6:0] decode(input state_t s);
    case (s)
      ST_ON:      decode = 7'b0111_100;
      ST_CLK_OFF: decode = 7'b0110_001;
      ST_ISO_ON:  decode = 7'b0010_001;
      ST_RST_ON:  decode = 7'b0000_001;
      ST_SW_OFF:  decode = 7'b1000_001;
      ST_OFF:     decode = 7'b1000_010;
      ST_SW_ON:   decode = 7'b0000_001;
      ST_RST_OFF: decode = 7'b0010_001;
      ST_ISO_OFF: decode = 7'b0110_001;
      ST_CLK_ON:  decode = 7'b0111_001;
      default:    decode = 7'b0111_100;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    step_d    = 8'd0;
    ack_cnt_d = 16'd0;
    timeout_d = 1'b0;
    case (state_q)
      ST_ON:  if (pd.off_req_i)  state_d = ST_CLK_OFF; else state_d = ST_ON;
      ST_OFF: if (!pd.off_req_i) state_d = ST_SW_ON;   else state_d = ST_OFF;
      ST_CLK_OFF, ST_ISO_ON, ST_RST_ON, ST_RST_OFF, ST_ISO_OFF, ST_CLK_ON: begin
        step_d = step_q + 8'd1;
        if (step_q == STEP_LAST) begin
          case (state_q)
            ST_CLK_OFF: state_d = ST_ISO_ON;
            ST_ISO_ON:  state_d = ST_RST_ON;
            ST_RST_ON:  state_d = ST_SW_OFF;
            ST_RST_OFF: state_d = ST_ISO_OFF;
            ST_ISO_OFF: state_d = ST_CLK_ON;
            default:    state_d = ST_ON;
          endcase
        end else begin
          state_d = state_q;
        end
      end
      // An ack seen on the final timeout cycle wins, so no timeout is flagged then.
      ST_SW_OFF: begin
        ack_cnt_d = ack_cnt_q + 16'd1;
        if (ack_s_q) begin
          state_d = ST_OFF;
        end else if (ack_cnt_q == ACK_LAST) begin
          state_d   = ST_OFF;
          timeout_d = 1'b1;
        end else begin
          state_d = ST_SW_OFF;
        end
      end
      ST_SW_ON: begin
        ack_cnt_d = ack_cnt_q + 16'd1;
        if (!ack_s_q) begin
          state_d = ST_RST_OFF;
        end else if (ack_cnt_q == ACK_LAST) begin
          state_d   = ST_RST_OFF;
          timeout_d = 1'b1;
        end else begin
          state_d = ST_SW_ON;
        end
      end
      default: state_d = ST_ON;
    endcase
    if (state_d != state_q) begin
      step_d    = 8'd0;
      ack_cnt_d = 16'd0;
    end else begin
      step_d    = step_d;
    end
  end

  // Outputs are registered from the next state so they always equal the decode of state_q.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q   <= 1'b0;
      ack_s_q   <= 1'b0;
      state_q   <= ST_ON;
      step_q    <= 8'd0;
      ack_cnt_q <= 16'd0;
      timeout_q <= 1'b0;
      outs_q    <= 7'b0111_100;
    end else begin
      sync1_q   <= pd.switch_ack_n_i;
      ack_s_q   <= sync1_q;
      state_q   <= state_d;
      step_q    <= step_d;
      ack_cnt_q <= ack_cnt_d;
      timeout_q <= timeout_d;
      outs_q    <= decode(state_d);
    end
  end

  assign {pd.switch_n_o, pd.iso_n_o, pd.rst_n_o, pd.clk_en_o, pd.on_o, pd.off_o, pd.busy_o} = outs_q;
  assign pd.timeout_o = timeout_q;

endmodule

// File: tb/tb_power_domain_seq.sv
// Randomized scoreboard bench for power_domain_seq against a step-table reference model.
module tb_power_domain_seq;
  localparam int STEP = 4;
  localparam int TOUT = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  power_domain_seq_if pd ();
  power_domain_seq #(.STEP_CYCLES(STEP), .ACK_TIMEOUT(TOUT)) dut (.clk_i(clk), .rst_i(rst), .pd(pd));

  int checks = 0;
  int failures = 0;

  // Phases in sequence order: ON, CLK_OFF, ISO_ON, RST_ON, SW_OFF, OFF, SW_ON, RST_OFF, ISO_OFF, CLK_ON
  logic [3:0] tbl [10] = '{4'b0111, 4'b0110, 4'b0010, 4'b0000, 4'b1000,
                           4'b1000, 4'b0000, 4'b0010, 4'b0110, 4'b0111};
  int m_phase = 0;
  int m_elapsed = 0;
  bit m_tout = 1'b0;
  bit ack_hist [$];
  int model_tout_cnt = 0;
  int dut_tout_cnt = 0;
  logic [7:0] exp_q [$];

  function automatic logic [7:0] expvec();
    return {tbl[m_phase], m_phase == 0, m_phase == 5, (m_phase != 0) && (m_phase != 5), m_tout};
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_elapsed = 0;
    m_tout = 1'b0;
    ack_hist.delete();
  endtask

  task automatic model_edge(input bit off_req, input bit ack_n);
    bit ack_s;
    int nxt;
    ack_s = (ack_hist.size() >= 2) ? ack_hist[ack_hist.size() - 2] : 1'b0;
    ack_hist.push_back(ack_n);
    if (ack_hist.size() > 2) void'(ack_hist.pop_front());
    nxt = m_phase;
    m_tout = 1'b0;
    case (m_phase)
      0: if (off_req) nxt = 1;
      5: if (!off_req) nxt = 6;
      4, 6: begin
        if (ack_s == (m_phase == 4)) nxt = m_phase + 1;
        else if (m_elapsed + 1 >= TOUT) begin nxt = m_phase + 1; m_tout = 1'b1; end
      end
      default: if (m_elapsed + 1 >= STEP) nxt = (m_phase == 9) ? 0 : m_phase + 1;
    endcase
    if (m_tout) model_tout_cnt++;
    m_elapsed = (nxt != m_phase) ? 0 : m_elapsed + 1;
    m_phase = nxt;
  endtask

  task automatic drive(input bit off_req, input bit ack_n);
    pd.off_req_i = off_req;
    pd.switch_ack_n_i = ack_n;
    model_edge(off_req, ack_n);
    exp_q.push_back(expvec());
  endtask

  task automatic check_now(input string name, input logic [7:0] req);
    logic [7:0] act;
    act = {pd.switch_n_o, pd.iso_n_o, pd.rst_n_o, pd.clk_en_o, pd.on_o, pd.off_o, pd.busy_o, pd.timeout_o};
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, req);
    end
  endtask

  // Monitor: each cycle the DUT presents an output vector that is matched against the queue head.
  always @(negedge clk) begin
    if (!rst && exp_q.size() > 0) begin
      if (pd.timeout_o === 1'b1) dut_tout_cnt++;
      check_now("cycle_outputs", exp_q.pop_front());
    end
  end

  // Switch environment: ack_n follows the commanded switch after a random delay, unless stuck.
  bit ack_n_cur = 1'b0;
  int dly_left = -1;
  bit stuck = 1'b1;
  int rolls = 0;
  bit off_req = 1'b0;
  int hold = 0;

  task automatic random_cycle();
    bit sw;
    bit ack_drv;
    if ((m_phase == 1 || m_phase == 6) && m_elapsed == 0) begin
      if (rolls > 0) stuck = ($urandom_range(0, 4) == 0);
      rolls++;
    end
    sw = tbl[m_phase][3];
    if (sw != ack_n_cur && !stuck) begin
      if (dly_left < 0) dly_left = $urandom_range(0, 14);
      else if (dly_left == 0) begin ack_n_cur = sw; dly_left = -1; end
      else dly_left--;
    end else begin
      dly_left = -1;
    end
    if (hold == 0) begin
      off_req = ~off_req;
      hold = $urandom_range(1, 40);
    end else begin
      hold--;
    end
    ack_drv = ack_n_cur;
    if (m_phase == 0 && $urandom_range(0, 19) == 0) ack_drv = ~ack_n_cur;
    @(negedge clk); #1;
    drive(off_req, ack_drv);
  endtask

  task automatic release_reset();
    @(negedge clk); #1;
    rst = 1'b0;
    model_reset();
    drive(off_req, ack_n_cur);
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    pd.off_req_i = 1'b0;
    pd.switch_ack_n_i = 1'b0;
    #1;
    check_now("reset_values", 8'b0111_1000);
    repeat (2) @(posedge clk);
    #1;
    check_now("reset_held", 8'b0111_1000);
    release_reset();

    repeat (1500) random_cycle();

    // Drive into RST_ON, then assert reset between edges.
    off_req = 1'b1;
    hold = 1000;
    guard = 0;
    while (m_phase != 3 && guard < 300) begin
      random_cycle();
      guard++;
    end
    checks++;
    if (m_phase != 3) begin
      failures++;
      $display("FAIL reach_rst_on actual_phase=%0d required=3", m_phase);
    end
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check_now("async_reset_mid_seq", 8'b0111_1000);
    exp_q.delete();
    repeat (2) @(posedge clk);
    hold = 0;
    off_req = 1'b1;
    release_reset();

    repeat (500) random_cycle();
    @(negedge clk); #2;

    checks++;
    if (dut_tout_cnt != model_tout_cnt || model_tout_cnt == 0) begin
      failures++;
      $display("FAIL timeout_pulses actual=%0d required=%0d (nonzero)", dut_tout_cnt, model_tout_cnt);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
